// File: rtl/mod_sub_pipe_if.sv
// rtl/mod_sub_pipe_if.sv - valid/ready operand and result streams for mod_sub_pipe
//
// Purpose: bundles the operand stream (in_*, op1/op2/tag) and the result
// stream (out_*, res/tag/range_err) of the modular subtractor.
// Modports:
//   slave  - the subtractor: consumes operands, produces results.
//   master - the producer/consumer around it (testbench or upstream logic).
interface mod_sub_pipe_if #(
  parameter int DATA_WIDTH = 255,
  parameter int TAG_WIDTH  = 8
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] op1_i;
  logic [DATA_WIDTH-1:0] op2_i;
  logic [TAG_WIDTH-1:0]  tag_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] res_o;
  logic [TAG_WIDTH-1:0]  tag_o;
  logic                  range_err_o;

  modport slave (
    input  in_valid_i, op1_i, op2_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, tag_o, range_err_o
  );

  modport master (
    output in_valid_i, op1_i, op2_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, tag_o, range_err_o
  );
endinterface

// File: rtl/mod_sub_pipe.sv
// rtl/mod_sub_pipe.sv - two-stage pipelined modular subtractor (op1 - op2) mod MODULUS
//
// Purpose: res = (op1 - op2) mod MODULUS with a fixed two-stage pipeline,
// full valid/ready backpressure and a tag carried alongside each operation.
//   S1: registers the DATA_WIDTH+1 bit difference {borrow, diff} and the tag.
//   S2: adds MODULUS back when a borrow occurred, registers result and tag.
// Ports:
//   clk_i - clock, rising edge.
//   rst_i - asynchronous active-high reset, discards everything in flight.
//   bus   - mod_sub_pipe_if.slave: in_valid_i/in_ready_o/op1_i/op2_i/tag_i
//           operand stream, out_valid_o/out_ready_i/res_o/tag_o/range_err_o
//           result stream.
// Option: MOD_SUB_RANGE_CHECK_EN adds an operand range flag that travels
// with each operation to range_err_o; without it range_err_o is constant 0.
module mod_sub_pipe #(
  parameter int                    DATA_WIDTH = 255,
  parameter logic [DATA_WIDTH-1:0] MODULUS    =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001,
  parameter int                    TAG_WIDTH  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mod_sub_pipe_if.slave bus
);

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_borrow_q, s1_borrow_d;
  logic [DATA_WIDTH-1:0] s1_diff_q, s1_diff_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_res_q, s2_res_d;
  logic [TAG_WIDTH-1:0]  s2_tag_q, s2_tag_d;

  logic                  s1_adv;
  logic                  s2_adv;
  logic                  accept;
  logic [DATA_WIDTH:0]   sub_full;

  // A stage may take new data when it is empty or its content moves on.
  // in_ready therefore depends only on downstream state, never on in_valid.
  always_comb begin
    s2_adv   = !s2_valid_q || bus.out_ready_i;
    s1_adv   = !s1_valid_q || s2_adv;
    accept   = bus.in_valid_i && s1_adv;
    sub_full = {1'b0, bus.op1_i} - {1'b0, bus.op2_i};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_borrow_d = s1_borrow_q;
    s1_diff_d   = s1_diff_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_res_d    = s2_res_q;
    s2_tag_d    = s2_tag_q;

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_borrow_d = sub_full[DATA_WIDTH];
      s1_diff_d   = sub_full[DATA_WIDTH-1:0];
      s1_tag_d    = bus.tag_i;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end

    // With in-range operands diff + MODULUS after a borrow wraps back into
    // [0, MODULUS-1], so a single conditional correction suffices.
    if (s1_valid_q && s2_adv) begin
      s2_res_d = s1_borrow_q ? (s1_diff_q + MODULUS) : s1_diff_q;
      s2_tag_d = s1_tag_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_borrow_q <= 1'b0;
      s1_diff_q   <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_borrow_q <= s1_borrow_d;
      s1_diff_q   <= s1_diff_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_res_q    <= s2_res_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

`ifdef MOD_SUB_RANGE_CHECK_EN
  logic s1_err_q, s1_err_d;
  logic s2_err_q, s2_err_d;

  // The flag follows exactly the same load enables as the data it describes.
  always_comb begin
    s1_err_d = s1_err_q;
    s2_err_d = s2_err_q;
    if (accept) begin
      s1_err_d = (bus.op1_i >= MODULUS) || (bus.op2_i >= MODULUS);
    end
    if (s1_valid_q && s2_adv) begin
      s2_err_d = s1_err_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_err_q <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      s1_err_q <= s1_err_d;
      s2_err_q <= s2_err_d;
    end
  end

  assign bus.range_err_o = s2_err_q;
`else
  assign bus.range_err_o = 1'b0;
`endif

  assign bus.in_ready_o  = s1_adv;
  assign bus.out_valid_o = s2_valid_q;
  assign bus.res_o       = s2_res_q;
  assign bus.tag_o       = s2_tag_q;

endmodule

// File: tb/tb_mod_sub_pipe.sv
// tb/tb_mod_sub_pipe.sv - self-checking bench for mod_sub_pipe
module tb_mod_sub_pipe;

  localparam int DW = 255;
  localparam int TW = 8;
  localparam logic [DW-1:0] P =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
  localparam logic [DW-1:0] P_M1 =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000000;
  localparam logic [DW-1:0] P_M2 =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfefffffffeffffffff;

  logic clk;
  logic rst;

  mod_sub_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  mod_sub_pipe #(.DATA_WIDTH(DW), .MODULUS(P), .TAG_WIDTH(TW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Field difference from the arithmetic definition: add p back when b > a.
  function automatic logic [DW-1:0] model_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [255:0] wa;
    logic [255:0] wb;
    logic [255:0] r;
    wa = {1'b0, a};
    wb = {1'b0, b};
    if (wa >= wb) r = wa - wb;
    else          r = wa + {1'b0, P} - wb;
    return r[DW-1:0];
  endfunction

  function automatic logic model_err(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MOD_SUB_RANGE_CHECK_EN
    return (a >= P) || (b >= P);
`else
    return 1'b0 & (a[0] | b[0]);
`endif
  endfunction

  function automatic logic [DW-1:0] rand_fe();
    logic [255:0] r;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return '0;
    if (sel == 1) return P_M1;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[255] = 1'b0;
    r = r % {1'b0, P};
    return r[DW-1:0];
  endfunction

  // Scoreboard: compares every cycle a result is presented, and checks that a
  // stalled result holds still until it is taken.
  initial begin
    logic          hold_prev;
    logic [DW-1:0] prev_res;
    logic [TW-1:0] prev_tag;
    logic          prev_err;
    exp_t          e;
    hold_prev = 1'b0;
    prev_res  = '0;
    prev_tag  = '0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("stall_valid", bus.out_valid_o, 1'b1);
          chk("stall_res", bus.res_o, prev_res);
          chk("stall_tag", bus.tag_o, prev_tag);
          chk("stall_err", bus.range_err_o, prev_err);
        end
        if (bus.out_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1'b1, 1'b0);
          end else begin
            e = exp_q[0];
            chk("sb_res", bus.res_o, e.res);
            chk("sb_tag", bus.tag_o, e.tag);
            chk("sb_err", bus.range_err_o, e.err);
            if (bus.out_ready_i) begin
              void'(exp_q.pop_front());
              out_cnt++;
            end
          end
        end
        if (bus.in_valid_i && bus.in_ready_o) begin
          e.res = model_sub(bus.op1_i, bus.op2_i);
          e.tag = bus.tag_i;
          e.err = model_err(bus.op1_i, bus.op2_i);
          exp_q.push_back(e);
          acc_cnt++;
        end
        hold_prev = bus.out_valid_o && !bus.out_ready_i;
        prev_res  = bus.res_o;
        prev_tag  = bus.tag_o;
        prev_err  = bus.range_err_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // One isolated operation into an empty pipe with out_ready held high:
  // accepted on the first edge, visible after the second, gone after the third.
  task automatic send_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t,
                          input logic [DW-1:0] exp_r, input logic exp_e, input string nm);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.op1_i       = a;
    bus.op2_i       = b;
    bus.tag_i       = t;
    chk({nm, "_in_ready"}, bus.in_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    chk({nm, "_early"}, bus.out_valid_o, 1'b0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, bus.out_valid_o, 1'b1);
    chk({nm, "_res"}, bus.res_o, exp_r);
    chk({nm, "_tag"}, bus.tag_o, t);
    chk({nm, "_err"}, bus.range_err_o, exp_e);
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, bus.out_valid_o, 1'b0);
  endtask

  initial begin
    int start_cnt;
    int sent;
    int budget;
    logic fired;

    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.op1_i       = '0;
    bus.op2_i       = '0;
    bus.tag_i       = '0;

    // Model pinned against hand-computed values.
    chk("model_5_3", model_sub(255'd5, 255'd3), 255'd2);
    chk("model_3_5", model_sub(255'd3, 255'd5), P_M2);
    chk("model_0_pm1", model_sub(255'd0, P_M1), 255'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_res", bus.res_o, '0);
    chk("rst_tag", bus.tag_o, '0);
    chk("rst_err", bus.range_err_o, 1'b0);
    chk("rst_in_ready", bus.in_ready_o, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready_o, 1'b1);
    chk("post_rst_out_valid", bus.out_valid_o, 1'b0);

    send_one(255'd5, 255'd3, 8'h11, 255'd2, 1'b0, "basic");
    send_one(255'd3, 255'd5, 8'h12, P_M2, 1'b0, "borrow");
    send_one(255'd0, P_M1, 8'h13, 255'd1, 1'b0, "zero_minus_pm1");
    send_one(P_M1, P_M1, 8'h14, 255'd0, 1'b0, "equal_pm1");

    // Streaming: 100 back-to-back, one result per cycle.
    bus.out_ready_i = 1'b1;
    start_cnt = out_cnt;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid_i = 1'b1;
      bus.op1_i      = rand_fe();
      bus.op2_i      = rand_fe();
      bus.tag_i      = 8'(i);
      chk("stream_in_ready", bus.in_ready_o, 1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("stream_count", 32'(out_cnt - start_cnt), 32'd100);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Random backpressure on both sides.
    sent   = 0;
    budget = 0;
    fired  = 1'b0;
    while (sent < 1000 && budget < 20000) begin
      if (!bus.in_valid_i || fired) begin
        bus.in_valid_i = 1'($urandom_range(0, 1));
        bus.op1_i      = rand_fe();
        bus.op2_i      = rand_fe();
        bus.tag_i      = 8'(sent);
      end
      bus.out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      fired = bus.in_valid_i && bus.in_ready_o;
      if (fired) sent++;
      @(posedge clk); #1;
      budget++;
    end
    chk("bp_sent", 32'(sent), 32'd1000);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_in_out_count", 32'(out_cnt), 32'(acc_cnt));

    // Reset with two operations in flight and output stalled.
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.op1_i       = 255'd10;
    bus.op2_i       = 255'd4;
    bus.tag_i       = 8'hA0;
    @(posedge clk); #1;
    bus.op1_i       = 255'd4;
    bus.op2_i       = 255'd10;
    bus.tag_i       = 8'hA1;
    @(posedge clk); #1;
    bus.in_valid_i  = 1'b0;
    chk("flight_out_valid", bus.out_valid_o, 1'b1);
    chk("flight_full_in_ready", bus.in_ready_o, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", bus.out_valid_o, 1'b0);
    chk("async_rst_res", bus.res_o, '0);
    chk("async_rst_tag", bus.tag_o, '0);
    chk("async_rst_in_ready", bus.in_ready_o, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("after_rst_no_stale", bus.out_valid_o, 1'b0);
      @(posedge clk); #1;
    end
    chk("after_rst_in_ready", bus.in_ready_o, 1'b1);

`ifdef MOD_SUB_RANGE_CHECK_EN
    send_one(P, 255'd0, 8'h55, P, 1'b1, "range_hi");
    send_one(255'd7, 255'd2, 8'h56, 255'd5, 1'b0, "range_ok");
`else
    send_one(P, 255'd0, 8'h55, P, 1'b0, "range_off");
    send_one(255'd7, 255'd2, 8'h56, 255'd5, 1'b0, "range_ok");
`endif

    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_sub_pipe.md
# mod_sub_pipe

Pipelined modular subtractor computing res = (op1 − op2) mod MODULUS over the scalar field used by the Poseidon datapath. It is the inverse-direction companion to the field adder and feeds the MDS/round-constant stages wherever a field negation or difference is required. Operands and results travel on valid/ready streams with a fixed two-stage pipeline and full backpressure support. A tag rides alongside each operation so consumers can reorder or match results.

## Interface
- DATA_WIDTH, 255: operand/result width in bits.
- MODULUS, 255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001: field modulus p.
- TAG_WIDTH, 8: width of the sideband tag carried with each operation.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  1  operand pair valid.
- in_ready_o  output  1  block accepts the operand pair this cycle.
- op1_i  input  DATA_WIDTH  minuend, must be < MODULUS.
- op2_i  input  DATA_WIDTH  subtrahend, must be < MODULUS.
- tag_i  input  TAG_WIDTH  sideband tag.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- res_o  output  DATA_WIDTH  (op1 − op2) mod MODULUS.
- tag_o  output  TAG_WIDTH  tag of the operation in res_o.
- range_err_o  output  1  operand out of range (MOD_SUB_RANGE_CHECK_EN only; tied 0 otherwise).

## Operation
- Stage 1 (S1): on accept, register {borrow, diff} = {1'b0, op1} − {1'b0, op2} as a DATA_WIDTH+1-bit subtraction; register tag.
- Stage 2 (S2): res = borrow ? diff + MODULUS (truncated to DATA_WIDTH) : diff; register res, tag.
- For in-range operands the result is always in [0, MODULUS−1]; no second correction is needed.
- Handshake: transfer occurs on a cycle with valid && ready on that interface. Once out_valid_o is high, res_o/tag_o/range_err_o hold stable until the transfer completes.
- Control: s2_adv = !s2_valid | out_ready_i; s1_adv = !s1_valid | s2_adv; in_ready_o = s1_adv (combinational, no dependency on in_valid_i).
- S1 loads on in_valid_i && in_ready_o; S1 valid clears when it advances with no new input. S2 loads from S1 when s1_valid && s2_adv.
- Operations exit strictly in acceptance order; no reordering, no drop.
- Reset: s1_valid, s2_valid, out_valid_o = 0; res_o, tag_o, range_err_o and all datapath registers = 0. After reset in_ready_o = 1.
- Reset asserted mid-operation discards all in-flight operations immediately; nothing is emitted for them after release.

## Timing
- Latency: 2 cycles from accept to out_valid_o when out_ready_i is held high.
- Throughput: one operation per cycle with out_ready_i held high.
- Stalled output: both stages fill; in_ready_o drops to 0 the cycle after S1 fills while out_ready_i = 0.
- Simultaneous output transfer and new input on a full pipe: both occur in the same cycle; no bubble.
- Backpressure release: in_ready_o rises combinationally in the same cycle out_ready_i rises.

## Configuration
- MOD_SUB_RANGE_CHECK_EN defined: S1 also registers err = (op1_i >= MODULUS) | (op2_i >= MODULUS); it travels with the operation and appears on range_err_o alongside its result. The result value is still computed by the same formula (undefined field value). range_err_o resets to 0.
- Not defined: no comparators are synthesized; range_err_o is constant 0.

## Test plan
- Basic: op1=5, op2=3, tag=0x11, out_ready_i=1 -> 2 cycles later res_o=2, tag_o=0x11, out_valid_o high for one cycle.
- Borrow: op1=3, op2=5 -> res_o=73eda753299d7d483339d80809a1d80553bda402fffe5bfefffffffeffffffff (p−2); op1=0, op2=p−1 -> res_o=1; op1=op2=p−1 -> res_o=0.
- Streaming: 100 back-to-back random in-range pairs with incrementing tags, out_ready_i=1 -> 100 results in order, one per cycle, each matching a golden model.
- Backpressure: random in_valid_i/out_ready_i toggling (50% each) over 1000 ops -> no loss, duplication or reordering; res_o/tag_o stable whenever out_valid_o && !out_ready_i.
- Reset mid-flight: accept 2 ops, hold out_ready_i=0, assert rst_i asynchronously -> out_valid_o=0, res_o=0 immediately; after release no stale result appears and in_ready_o=1.
- Range check (macro defined): op1=MODULUS, op2=0 -> range_err_o=1 with that result; next op 7−2 -> res_o=5, range_err_o=0; macro undefined -> range_err_o always 0.
